// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default baud divisor and
// ASCII codes the command decoder matches against.
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // 12 MHz / 115200 baud
  localparam int RX_CLKS_PER_BIT_DEF = 104;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_5  = 8'h35;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_A  = 8'h61;
  localparam logic [7:0] ASCII_L  = 8'h6C;
  localparam logic [7:0] ASCII_AT = 8'h40;

endpackage

// File: rtl/uart_rx_deser_sync2.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to
// RST_VAL so an idle line does not look like an edge after reset.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver: oversamples rxd, samples each bit at its midpoint and
// emits each good byte with a one-cycle ready strobe (framing errors likewise).
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = RX_CLKS_PER_BIT_DEF,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] bu_rx_data,
  output logic       bu_rx_data_rdy,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic [7:0]       data_n;
  logic             rdy_n, err_n;
  logic             rx_s, rx_prev;
  logic             cnt_zero;

  sync2 #(.RST_VAL(1'b1)) u_sync_rxd (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rx_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= RX_IDLE;
      cnt            <= '0;
      bit_idx        <= '0;
      shreg          <= '0;
      bu_rx_data     <= 8'h00;
      bu_rx_data_rdy <= 1'b0;
      rx_frame_err   <= 1'b0;
      rx_prev        <= 1'b1;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      bit_idx        <= bit_idx_n;
      shreg          <= shreg_n;
      bu_rx_data     <= data_n;
      bu_rx_data_rdy <= rdy_n;
      rx_frame_err   <= err_n;
      rx_prev        <= rx_s;
    end
  end

  assign cnt_zero = (cnt == '0);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    data_n    = bu_rx_data;
    rdy_n     = 1'b0;
    err_n     = 1'b0;
    case (state)
      RX_IDLE: begin
        // Only a genuine 1->0 transition starts a frame; a stuck-low line does not.
        if (rx_prev && !rx_s) begin
          state_n = RX_START;
          cnt_n   = HALF_LOAD;
        end
      end
      RX_START: begin
        if (cnt_zero) begin
          if (!rx_s) begin
            state_n   = RX_DATA;
            cnt_n     = BIT_LOAD;
            bit_idx_n = 3'd0;
          end else begin
            state_n = RX_IDLE;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_zero) begin
          shreg_n   = {rx_s, shreg[7:1]};
          cnt_n     = BIT_LOAD;
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = RX_STOP;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_zero) begin
          if (rx_s) begin
            data_n = shreg;
            rdy_n  = 1'b1;
          end else begin
            err_n = 1'b1;
          end
          state_n = RX_IDLE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  assign rx_busy = (state != RX_IDLE);

endmodule

// File: doc/uart_rx_deser.md
Name: uart_rx_deser

Overview:
- Asynchronous serial receiver that feeds the alarm-clock command path.
- Oversamples the FTDI RX line, deserialises 8N1 frames (LSB first), and presents each received byte as an 8-bit value with a one-cycle ready strobe.
- Its outputs drive the bu_rx_data / bu_rx_data_rdy inputs of the clock top level directly.
- Also reports framing errors and busy status so line faults can be shown on the LEDs.

Parameters:
CLKS_PER_BIT, 104, clk cycles per bit period (12 MHz / 115200 ≈ 104); legal range 8..65535
CNT_W, 16, width of the baud counter; must hold CLKS_PER_BIT-1

Ports:
clk  input  1  global clock
rst  input  1  reset, asynchronous, active-low (0 = reset)
rxd  input  1  raw serial line, idle high, asynchronous to clk
bu_rx_data  output  8  last good received byte; held until the next good byte
bu_rx_data_rdy  output  1  one-cycle strobe; bu_rx_data is valid and new in that cycle
rx_frame_err  output  1  one-cycle strobe; stop bit sampled low
rx_busy  output  1  high from start-bit detection until return to IDLE

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; baud counter=0; bit index=0; shift register=0.
  - bu_rx_data=8'h00; bu_rx_data_rdy=0; rx_frame_err=0; rx_busy=0.
  - Both synchronizer flops and the previous-sample flop reset to 1 (line idle).
- Synchronisation: rxd passes through 2 flops (rx_s). rx_prev is rx_s delayed one cycle. All FSM decisions use rx_s only.
- IDLE:
  - Start edge = rx_prev=1 and rx_s=0.
  - On start edge: load counter with CLKS_PER_BIT/2 - 1 (integer division), go to START, rx_busy=1.
  - A line that stays low never re-triggers; a fresh 1→0 edge is required.
- START:
  - Counter decrements each cycle. At 0, sample rx_s.
  - rx_s=0: reload counter with CLKS_PER_BIT-1, bit index=0, go to DATA.
  - rx_s=1: treat as a glitch and return to IDLE. No strobe, no error.
- DATA:
  - At each counter expiry, shift rx_s into the MSB of the shift register (right shift), so bit 0 is received first.
  - Then reload the counter and increment the bit index.
  - After the 8th sample (index 7), reload the counter and go to STOP.
- STOP, at counter expiry:
  - rx_s=1: bu_rx_data ← shift register; bu_rx_data_rdy=1 for exactly the next cycle.
  - rx_s=0: rx_frame_err=1 for exactly the next cycle; bu_rx_data unchanged; no rdy.
  - In both cases go to IDLE and drop rx_busy in the same cycle as the strobe.
- Latency: rdy rises 2 (sync) + 1 (edge) + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles (±1) after the rxd falling edge.
- Back-to-back frames: the start edge of frame N+1 may arrive immediately after the stop-bit mid-sample; IDLE must catch it. No frames lost at 100 % line utilisation.
- Strobes: bu_rx_data_rdy and rx_frame_err are never high simultaneously, and each is never high for two consecutive cycles.
- No overrun handling. The consumer must accept data on the strobe cycle; bu_rx_data simply holds the latest byte.
- Reset mid-frame: immediate abort to IDLE with reset values. A partially received byte is never presented.
- Counter arithmetic: unsigned CNT_W bits, decrement-to-zero, no wrap (always reloaded at 0).

Decomposition:
- Shared package uart_pkg:
  - rx state enum (IDLE, START, DATA, STOP) as 2-bit localparams.
  - Default CLKS_PER_BIT.
  - ASCII constants used by the command decoder: '0'=8'h30, '5'=8'h35, '9'=8'h39, CR=8'h0D, 'a'=8'h61, 'l'=8'h6C, '@'=8'h40.
- One natural sub-module: sync2 (2-flop synchronizer, reset value parameter, async active-low reset), instantiated for rxd.

Test Plan:
- Reset hold: rst=0 for 5 cycles while rxd toggles → all outputs 0 and rx_busy=0. Release with rxd=1 → no strobe for 20 bit times.
- Single byte: with CLKS_PER_BIT=16, send 0x61 ('a') as 8N1 → exactly one rdy pulse, bu_rx_data=8'h61 from then on. rdy arrives within 154±2 cycles of the start edge.
- Back-to-back: send "l1234\r" (0x6C 0x31 0x32 0x33 0x34 0x0D) with zero idle between frames → 6 rdy pulses with data in order. rx_frame_err is never asserted.
- Framing error: send 0x40 with the stop bit driven 0, then hold rxd low 3 bit times, then high → one rx_frame_err pulse, no rdy, bu_rx_data keeps its previous value. Next valid frame 0x35 → rdy with 8'h35.
- Glitch rejection: rxd low for 3 cycles (< CLKS_PER_BIT/2) then high → return to IDLE, no strobes, rx_busy pulse only.
- Mid-frame reset: assert rst=0 during bit 4 of 0xFF, then release and send 0x00 → only one rdy, with data 8'h00.
